// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: per-key synchroniser, filter FSM, press/release pulses.
// Define KEY_FILTER_LONG_EN to build the long-press detector (Key_L_Flag).
module key_filter_multi #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] Key,
    output logic [NUM_KEYS-1:0] Key_P_Flag,
    output logic [NUM_KEYS-1:0] Key_R_Flag,
    output logic [NUM_KEYS-1:0] Key_State,
    output logic [NUM_KEYS-1:0] Key_L_Flag
);

    localparam int MAX_CNT = (DEBOUNCE_CYCLES > LONG_CYCLES) ?
                             DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CW = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic REL = (KEY_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        FILT_P,
        DOWN,
        FILT_R
    } state_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] p;
    logic [NUM_KEYS-1:0] p_flag_n;
    logic [NUM_KEYS-1:0] r_flag_n;

    state_t        state   [NUM_KEYS];
    state_t        state_n [NUM_KEYS];
    logic [CW-1:0] cnt     [NUM_KEYS];
    logic [CW-1:0] cnt_n   [NUM_KEYS];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= {NUM_KEYS{REL}};
            sync2 <= {NUM_KEYS{REL}};
        end else begin
            sync1 <= Key;
            sync2 <= sync1;
        end
    end

    assign p = REL ? ~sync2 : sync2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            Key_P_Flag <= '0;
            Key_R_Flag <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i] <= state_n[i];
                cnt[i]   <= cnt_n[i];
            end
            Key_P_Flag <= p_flag_n;
            Key_R_Flag <= r_flag_n;
        end
    end

    always_comb begin
        p_flag_n = '0;
        r_flag_n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_n[i] = state[i];
            cnt_n[i]   = cnt[i];
            unique case (state[i])
                IDLE: begin
                    cnt_n[i] = '0;
                    if (p[i]) state_n[i] = FILT_P;
                end
                FILT_P: begin
                    if (!p[i]) begin
                        state_n[i] = IDLE;
                        cnt_n[i]   = '0;
                    end else if (cnt[i] == DEB_LAST) begin
                        state_n[i]  = DOWN;
                        cnt_n[i]    = '0;
                        p_flag_n[i] = 1'b1;
                    end else begin
                        cnt_n[i] = cnt[i] + 1'b1;
                    end
                end
                DOWN: begin
                    cnt_n[i] = '0;
                    if (!p[i]) state_n[i] = FILT_R;
                end
                FILT_R: begin
                    if (p[i]) begin
                        state_n[i] = DOWN;
                        cnt_n[i]   = '0;
                    end else if (cnt[i] == DEB_LAST) begin
                        state_n[i]  = IDLE;
                        cnt_n[i]    = '0;
                        r_flag_n[i] = 1'b1;
                    end else begin
                        cnt_n[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_n[i] = IDLE;
                    cnt_n[i]   = '0;
                end
            endcase
        end
    end

    // Debounced level is high through the release filter window
    always_comb begin
        Key_State = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            Key_State[i] = (state[i] == DOWN) || (state[i] == FILT_R);
        end
    end

`ifdef KEY_FILTER_LONG_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    logic [CW-1:0]       lcnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] ldone;

    // ldone saturates the detector so a press yields at most one long pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_KEYS; i++) lcnt[i] <= '0;
            ldone      <= '0;
            Key_L_Flag <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                Key_L_Flag[i] <= 1'b0;
                if (state[i] == IDLE) begin
                    lcnt[i]  <= '0;
                    ldone[i] <= 1'b0;
                end else if (state[i] == DOWN && !ldone[i]) begin
                    if (lcnt[i] == LONG_LAST) begin
                        ldone[i]      <= 1'b1;
                        Key_L_Flag[i] <= 1'b1;
                    end else begin
                        lcnt[i] <= lcnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign Key_L_Flag = '0;
`endif

endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: directed scenarios plus random bounce,
// checked every cycle against a run-length reference model.
module tb_key_filter_multi;

    localparam int N = 4;
    localparam int D = 8;
    localparam int L = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key = '1;
    logic [N-1:0] pf;
    logic [N-1:0] rf;
    logic [N-1:0] ks;
    logic [N-1:0] lf;

    always #5 clk = ~clk;

    key_filter_multi #(
        .NUM_KEYS(N),
        .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW(1),
        .LONG_CYCLES(L)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .Key(key),
        .Key_P_Flag(pf),
        .Key_R_Flag(rf),
        .Key_State(ks),
        .Key_L_Flag(lf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, got, exp, $time);
    endtask

    // Reference: a level flips once the synchronised pin has disagreed
    // with it on D+1 consecutive samples; long pulse on the L-th
    // settled-pressed sample of a press.
    logic [N-1:0] m1  = '1;
    logic [N-1:0] m2  = '1;
    logic [N-1:0] lvl = '0;
    logic [N-1:0] e_p = '0;
    logic [N-1:0] e_r = '0;
    logic [N-1:0] e_l = '0;
    int  run    [N];
    int  lrun   [N];
    bit  lfired [N];
    bit  started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        e_p = '0;
        e_r = '0;
        e_l = '0;
        if (rst) begin
            lvl = '0;
            m1  = '1;
            m2  = '1;
            for (int c = 0; c < N; c++) begin
                run[c]    = 0;
                lrun[c]   = 0;
                lfired[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                logic pr;
                pr = ~m2[c];
                if (!lvl[c]) begin
                    lrun[c]   = 0;
                    lfired[c] = 1'b0;
                end else if (run[c] == 0 && !lfired[c]) begin
                    lrun[c]++;
                    if (lrun[c] == L) begin
                        lfired[c] = 1'b1;
`ifdef KEY_FILTER_LONG_EN
                        e_l[c] = 1'b1;
`endif
                    end
                end
                if (pr != lvl[c]) begin
                    run[c]++;
                    if (run[c] == D + 1) begin
                        if (lvl[c]) e_r[c] = 1'b1;
                        else        e_p[c] = 1'b1;
                        lvl[c] = ~lvl[c];
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            m2 = m1;
            m1 = key;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("press",   32'(pf), 32'(e_p));
            check("release", 32'(rf), 32'(e_r));
            check("state",   32'(ks), 32'(lvl));
            check("long",    32'(lf), 32'(e_l));
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Negedges from a pin change until the flag vector equals want
    task automatic latency(string tag, logic sel_r, logic [N-1:0] want);
        int  lat;
        bit  found;
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            lat++;
            if ((sel_r ? rf : pf) == want) found = 1'b1;
        end
        check(tag, 32'(lat), 32'(D + 3));
    endtask

    int hold [N];

    initial begin
        idle(3);
        rst = 1'b0;
        idle(5);

        key[0] = 1'b0;
        latency("clean_press_lat", 1'b0, 4'b0001);
        idle(10);
        key[0] = 1'b1;
        idle(15);

        key[1] = 1'b0;
        idle(5);
        key[1] = 1'b1;
        idle(3);
        key[1] = 1'b0;
        latency("bounce_press_lat", 1'b0, 4'b0010);
        idle(10);
        key[1] = 1'b1;
        idle(15);

        key[2] = 1'b0;
        idle(15);
        key[2] = 1'b1;
        idle(4);
        key[2] = 1'b0;
        idle(6);
        key[2] = 1'b1;
        latency("release_lat", 1'b1, 4'b0100);
        idle(15);

        key = '0;
        latency("simul_press_lat", 1'b0, 4'b1111);
        idle(15);
        key = '1;
        idle(15);

        key[0] = 1'b0;
        idle(8);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(30);
        key[0] = 1'b1;
        idle(20);

        key[0] = 1'b0;
        idle(60);
        key[0] = 1'b1;
        idle(20);

        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 12);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    key[c]  = ~key[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ?
                              $urandom_range(1, 45) :
                              $urandom_range(1, 12);
                end
            end
        end
        rst = 1'b0;
        key = '1;
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
